pc_unit: RTL and testbench

- Parametrised program-counter unit for the RV32I core; successor to the single-register PC.
- Holds the fetch PC and advances it under a fetch handshake with instruction memory.
- Applies stalls, branch/jump redirects and trap redirects in a fixed priority.
- Checks target alignment and supports halt/resume for debug; feeds the IF stage.

---
 rtl/pc_pkg.sv | 12 +
 rtl/pc_unit_if.sv | 14 +
 rtl/pc_next_sel.sv | 34 +++
 rtl/pc_unit.sv | 49 ++++
 tb/tb_pc_unit.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared states, alignment masks and increments for the program-counter unit
package pc_pkg;
    localparam int PC_XLEN = 32;
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;
    typedef enum logic [1:0] {BOOT = ST_BOOT, RUN = ST_RUN, HALT = ST_HALT} pc_state_e;
    localparam logic [1:0] ALIGN_MASK_32 = 2'b11;
    localparam logic [1:0] ALIGN_MASK_16 = 2'b01;
    localparam logic [2:0] INC_32 = 3'd4;
    localparam logic [2:0] INC_16 = 3'd2;
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch handshake and control bus between the core and pc_unit
interface pc_unit_if import pc_pkg::*; #(parameter int XLEN = PC_XLEN) ();
    logic fetch_ready, stall, redirect_valid, trap_valid, halt_req, resume, inst_is_16;
    logic [XLEN-1:0] redirect_target, pc, misalign_addr;
    logic pc_valid, misalign_err, halted;
    modport master(
        output fetch_ready, stall, redirect_valid, redirect_target, trap_valid, halt_req, resume, inst_is_16,
        input pc, pc_valid, misalign_err, misalign_addr, halted
    );
    modport slave(
        input fetch_ready, stall, redirect_valid, redirect_target, trap_valid, halt_req, resume, inst_is_16,
        output pc, pc_valid, misalign_err, misalign_addr, halted
    );
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-pc priority mux and alignment check; PC_UNIT_RVC_EN enables 2-byte steps/alignment
module pc_next_sel import pc_pkg::*; #(
    parameter int XLEN = PC_XLEN,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h0000_0100)
) (
    input  logic [XLEN-1:0] pc,
    input  logic            trap_valid,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            stall,
    input  logic            fetch_ready,
    input  logic            inst_is_16,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign
);
`ifdef PC_UNIT_RVC_EN
    localparam logic [1:0] ALIGN_MASK = ALIGN_MASK_16;
    logic [XLEN-1:0] inc;
    assign inc = XLEN'(inst_is_16 ? INC_16 : INC_32);
`else
    localparam logic [1:0] ALIGN_MASK = ALIGN_MASK_32;
    logic [XLEN-1:0] inc;
    logic unused_inst_is_16;
    assign inc = XLEN'(INC_32);
    assign unused_inst_is_16 = inst_is_16;
`endif
    // trap beats redirect; a bad redirect target falls back to the trap vector
    always_comb begin
        misalign = redirect_valid && !trap_valid && ((redirect_target[1:0] & ALIGN_MASK) != 2'b00);
        next_pc = (trap_valid || misalign) ? TRAP_VECTOR :
                  redirect_valid ? redirect_target :
                  (stall || !fetch_ready) ? pc : pc + inc;
    end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch PC register with BOOT/RUN/HALT control; PC_UNIT_RVC_EN handled in pc_next_sel
module pc_unit import pc_pkg::*; #(
    parameter int XLEN = PC_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h0000_0100)
) (
    input logic       clk,
    input logic       reset,
    pc_unit_if.slave  bus
);
    logic [1:0] state;
    logic [XLEN-1:0] next_pc;
    logic misalign, hold, go_halt;
    assign hold = bus.stall || bus.halt_req || state == ST_HALT;
    assign go_halt = (state == ST_HALT) ? !bus.resume : bus.halt_req;
    pc_next_sel #(.XLEN(XLEN), .TRAP_VECTOR(TRAP_VECTOR)) u_next_sel (
        .pc(bus.pc),
        .trap_valid(bus.trap_valid),
        .redirect_valid(bus.redirect_valid),
        .redirect_target(bus.redirect_target),
        .stall(hold),
        .fetch_ready(bus.fetch_ready),
        .inst_is_16(bus.inst_is_16),
        .next_pc(next_pc),
        .misalign(misalign)
    );
    // state machine and registered outputs; BOOT ignores inputs for one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_BOOT;
            bus.pc <= RESET_VECTOR;
            bus.pc_valid <= 1'b0;
            bus.misalign_err <= 1'b0;
            bus.misalign_addr <= '0;
            bus.halted <= 1'b0;
        end else if (state == ST_BOOT) begin
            state <= ST_RUN;
            bus.pc_valid <= 1'b1;
            bus.misalign_err <= 1'b0;
        end else begin
            state <= go_halt ? ST_HALT : ST_RUN;
            bus.pc <= next_pc;
            bus.pc_valid <= !go_halt;
            bus.halted <= go_halt;
            bus.misalign_err <= misalign;
            if (misalign) bus.misalign_addr <= bus.redirect_target;
        end
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vector table plus randomized run against a rule-level model
module tb_pc_unit;
    localparam logic [31:0] RV = 32'h0;
    localparam logic [31:0] TV = 32'h100;
`ifdef PC_UNIT_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    typedef struct {
        logic rst, fr, st, rv;
        logic [31:0] rt;
        logic tv, hr, rs, i16;
        logic [31:0] pc;
        logic v, err;
        logic [31:0] addr;
        logic h;
    } vec_t;

    logic clk = 0;
    logic reset;
    int n_checks = 0;
    int n_fail = 0;

    pc_unit_if #(.XLEN(32)) bus ();
    pc_unit #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] m_pc, m_addr;
    bit m_boot, m_halt, m_valid, m_err;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        reset = t.rst;
        bus.fetch_ready = t.fr;
        bus.stall = t.st;
        bus.redirect_valid = t.rv;
        bus.redirect_target = t.rt;
        bus.trap_valid = t.tv;
        bus.halt_req = t.hr;
        bus.resume = t.rs;
        bus.inst_is_16 = t.i16;
    endtask

    function automatic vec_t mk(input logic rst, fr, st, rv, input logic [31:0] rt, input logic tv, hr, rs,
                                input logic [31:0] pc, input logic v, err, input logic [31:0] addr, input logic h);
        vec_t t;
        t.rst = rst; t.fr = fr; t.st = st; t.rv = rv; t.rt = rt; t.tv = tv; t.hr = hr; t.rs = rs; t.i16 = 1'b0;
        t.pc = pc; t.v = v; t.err = err; t.addr = addr; t.h = h;
        return t;
    endfunction

    // Reference model: applies the architectural rules once per clock
    task automatic model(input vec_t t);
        int align, step;
        bit bad;
        logic [31:0] npc;
        align = RVC ? 2 : 4;
        step = (RVC && t.i16) ? 2 : 4;
        if (t.rst) begin
            m_pc = RV; m_boot = 1; m_halt = 0; m_valid = 0; m_err = 0; m_addr = 0;
        end else if (m_boot) begin
            m_boot = 0; m_valid = 1; m_err = 0;
        end else begin
            bad = t.rv && !t.tv && (t.rt % align != 0);
            if (t.tv || bad) npc = TV;
            else if (t.rv) npc = t.rt;
            else if (m_halt || t.hr || t.st || !t.fr) npc = m_pc;
            else npc = m_pc + 32'(step);
            m_pc = npc;
            m_err = bad;
            if (bad) m_addr = t.rt;
            m_halt = m_halt ? !t.rs : t.hr;
            m_valid = !m_halt;
        end
    endtask

    initial begin
        vec_t tbl[$];
        vec_t t;
        reset = 1;
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        //                rst fr st rv target          tv hr rs   pc            v  err addr         h
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,          0, 0, 0,  32'h0,        0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 0, 1, 32'h44,         1, 0, 0,  32'h0,        1, 0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,          0, 0, 0,  32'h4,        1, 0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,          0, 0, 0,  32'h8,        1, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,          0, 0, 0,  32'h8,        1, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,          0, 0, 0,  32'h8,        1, 0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,          0, 0, 0,  32'h8,        1, 0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,          0, 0, 0,  32'hC,        1, 0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,          0, 0, 0,  32'h10,       1, 0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,          0, 1, 0,  32'h10,       0, 0, 32'h0,        1));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,          0, 1, 0,  32'h10,       0, 0, 32'h0,        1));
        tbl.push_back(mk(0, 1, 0, 1, 32'h80,         0, 0, 0,  32'h80,       0, 0, 32'h0,        1));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,          0, 1, 1,  32'h80,       1, 0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,          0, 0, 0,  32'h84,       1, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h40,         0, 0, 0,  32'h40,       1, 0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 0, 1, 32'h40,         1, 0, 0,  32'h100,      1, 0, 32'h0,        0));
        if (RVC) begin
            tbl.push_back(mk(0, 1, 0, 1, 32'h42,     0, 0, 0,  32'h42,       1, 0, 32'h0,        0));
            tbl.push_back(mk(0, 1, 0, 0, 32'h0,      0, 0, 0,  32'h46,       1, 0, 32'h0,        0));
        end else begin
            tbl.push_back(mk(0, 1, 0, 1, 32'h42,     0, 0, 0,  32'h100,      1, 1, 32'h42,       0));
            tbl.push_back(mk(0, 1, 0, 0, 32'h0,      0, 0, 0,  32'h104,      1, 0, 32'h42,       0));
        end
        tbl.push_back(mk(0, 1, 0, 1, 32'hFFFF_FFFC,  0, 0, 0,  32'hFFFF_FFFC, 1, 0, RVC ? 32'h0 : 32'h42, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,          0, 0, 0,  32'h0,        1, 0, RVC ? 32'h0 : 32'h42, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h24,         0, 0, 0,  32'h24,       1, 0, RVC ? 32'h0 : 32'h42, 0));
        tbl.push_back(mk(1, 1, 0, 1, 32'h27,         0, 0, 0,  32'h0,        0, 0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,          0, 0, 0,  32'h0,        1, 0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 0, 1, 32'h3,          0, 0, 0,  32'h100,      1, 1, 32'h3,        0));
        tbl.push_back(mk(0, 1, 0, 1, 32'h5,          0, 0, 0,  32'h100,      1, 1, 32'h5,        0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,          0, 0, 0,  32'h100,      1, 0, 32'h5,        0));
        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            chk("pc", i, bus.pc, tbl[i].pc);
            chk("pc_valid", i, 32'(bus.pc_valid), 32'(tbl[i].v));
            chk("misalign_err", i, 32'(bus.misalign_err), 32'(tbl[i].err));
            chk("misalign_addr", i, bus.misalign_addr, tbl[i].addr);
            chk("halted", i, 32'(bus.halted), 32'(tbl[i].h));
        end
        for (int c = 0; c < 3000; c++) begin
            int kind;
            t = mk(c == 0 || $urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 5) == 0, 0, $urandom_range(0, 11) == 0, $urandom_range(0, 14) == 0,
                   $urandom_range(0, 3) == 0, 0, 0, 0, 0, 0);
            t.i16 = $urandom_range(0, 1) == 1;
            kind = $urandom_range(0, 2);
            t.rt = kind == 0 ? ($urandom() & 32'hFFFF_FFFC) : kind == 1 ? $urandom() :
                   32'hFFFF_FFF0 + 32'($urandom_range(0, 7) * 2);
            drive(t);
            model(t);
            @(posedge clk);
            #1;
            chk("rnd_pc", c, bus.pc, m_pc);
            chk("rnd_pc_valid", c, 32'(bus.pc_valid), 32'(m_valid));
            chk("rnd_misalign_err", c, 32'(bus.misalign_err), 32'(m_err));
            chk("rnd_misalign_addr", c, bus.misalign_addr, m_addr);
            chk("rnd_halted", c, 32'(bus.halted), 32'(m_halt));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
